// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard-controller FSM encoding and register constants.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_FAULT   = 2'd2
    } hazard_state_t;

    // Register 31 is never a real producer (zero/link style register), so it never creates a hazard.
    localparam logic [4:0]  REG_NO_HAZARD = 5'd31;

    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard comparator between the EX-stage load and the ID-stage sources.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rn,
    input  logic [4:0] id_rm,
    input  logic       id_uses_rm,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    // A load in EX whose destination feeds an ID source forces a one-cycle stall.
    always_comb begin
        load_use = ex_memread
                && (ex_rd != REG_NO_HAZARD)
                && ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory wait
// stalls with timeout fault, and a saturating PC-stall cycle counter.
//
// state   | meaning
// RUN     | normal flow; load-use stall / branch flush handled combinationally
// MEMWAIT | data memory busy; whole pipeline held until mem_ack
// FAULT   | memory timed out; pipeline held until Reset
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
)
(
    input  logic        clk,
    input  logic        Reset,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_rm,
    input  logic        id_uses_rm,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        back_stall,
    output logic        mem_fault,
    output logic [31:0] stall_cycles
);

    localparam int            CW          = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);

    hazard_state_t state;
    hazard_state_t state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_inc;
    logic          wait_clr;
    logic          wait_inc;
    logic          load_use;
    logic          mem_hold;

    hazard_detect u_hazard_detect (
        .id_rn      (id_rn),
        .id_rm      (id_rm),
        .id_uses_rm (id_uses_rm),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .load_use   (load_use)
    );

    assign wait_cnt_inc = wait_cnt + CW'(1);
    assign mem_fault    = (state == ST_FAULT);

    // Next-state logic and wait-counter control.
    always_comb begin
        state_nxt = state;
        wait_clr  = 1'b0;
        wait_inc  = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_req && !mem_ack) begin
                    state_nxt = ST_MEMWAIT;
                    wait_clr  = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                if (mem_ack) begin
                    state_nxt = ST_RUN;
                    wait_clr  = 1'b1;
                end else begin
                    wait_inc = 1'b1;
                    if (wait_cnt_inc == TIMEOUT_VAL) begin
                        state_nxt = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Output muxing: reset clears everything, then memory hold > branch flush > load-use stall.
    // A branch seen during a memory hold simply flushes once the hold drops, since EX is frozen.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        back_stall  = 1'b0;
        mem_hold    = (state == ST_MEMWAIT) || (state == ST_FAULT)
                   || ((state == ST_RUN) && mem_req && !mem_ack);
        if (Reset) begin
            pc_stall = 1'b0;
        end else if (mem_hold) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            back_stall = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Consecutive MEMWAIT cycle counter.
    always_ff @(posedge clk) begin
        if (Reset || wait_clr) begin
            wait_cnt <= '0;
        end else if (wait_inc) begin
            wait_cnt <= wait_cnt_inc;
        end
    end

    // Saturating count of cycles spent with the PC held.
    always_ff @(posedge clk) begin
        if (Reset) begin
            stall_cycles <= '0;
        end else if (pc_stall && (stall_cycles != STALL_CNT_MAX)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 8;

    logic        clk;
    logic        Reset;
    logic [4:0]  id_rn;
    logic [4:0]  id_rm;
    logic        id_uses_rm;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        mem_ack;
    logic        pc_stall;
    logic        ifid_stall;
    logic        idex_bubble;
    logic        ifid_flush;
    logic        idex_flush;
    logic        back_stall;
    logic        mem_fault;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: "waiting on memory", "faulted", cycles waited, stall count.
    bit          m_waiting;
    bit          m_faulted;
    int          m_waited;
    logic [31:0] m_sc;
    logic [6:0]  last_obs;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .Reset           (Reset),
        .id_rn           (id_rn),
        .id_rm           (id_rm),
        .id_uses_rm      (id_uses_rm),
        .ex_memread      (ex_memread),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .idex_bubble     (idex_bubble),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .back_stall      (back_stall),
        .mem_fault       (mem_fault),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected {pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush, back_stall, mem_fault}.
    function automatic logic [6:0] model_outs();
        bit hazard;
        bit held;
        hazard = ex_memread && (ex_rd != 5'd31)
              && ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
        held   = m_faulted || m_waiting || (mem_req && !mem_ack);
        if (Reset)                return {6'b000000, m_faulted};
        else if (held)            return {7'b1100010} | {6'b0, m_faulted};
        else if (ex_branch_taken) return 7'b0001100;
        else if (hazard)          return 7'b1110000;
        else                      return 7'b0000000;
    endfunction

    task automatic model_edge(input bit pc_held);
        if (Reset) begin
            m_waiting = 0;
            m_faulted = 0;
            m_waited  = 0;
            m_sc      = 32'd0;
        end else begin
            if (pc_held && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
            if (m_faulted) begin
                m_faulted = 1;
            end else if (m_waiting) begin
                if (mem_ack) begin
                    m_waiting = 0;
                    m_waited  = 0;
                end else begin
                    m_waited = m_waited + 1;
                    if (m_waited == TIMEOUT) begin
                        m_faulted = 1;
                        m_waiting = 0;
                    end
                end
            end else if (mem_req && !mem_ack) begin
                m_waiting = 1;
                m_waited  = 0;
            end
        end
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step(input string tag);
        logic [6:0] e;
        #1;
        e = model_outs();
        last_obs = {pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush, back_stall, mem_fault};
        chk({tag, "_outs"}, 64'(last_obs), 64'(e));
        @(posedge clk);
        model_edge(e[6]);
        @(negedge clk);
        chk({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(m_sc));
    endtask

    task automatic idle_inputs();
        id_rn = 5'd0; id_rm = 5'd0; id_uses_rm = 1'b0;
        ex_memread = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b1;
        step("reset");
        Reset = 1'b0;
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = int'($urandom_range(0, 5));
        if (r == 5) return 5'd31;
        return 5'(r);
    endfunction

    initial begin
        m_waiting = 0; m_faulted = 0; m_waited = 0; m_sc = 32'd0;
        idle_inputs();
        Reset = 1'b1;
        @(negedge clk);
        do_reset();
        chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
        chk("rst_fault", 64'(mem_fault), 64'd0);

        // Load-use on rn.
        ex_memread = 1'b1; ex_rd = 5'd3; id_rn = 5'd3;
        step("lu_rn");
        chk("lu_rn_vec", 64'(last_obs), 64'(7'b1110000));
        chk("lu_rn_sc", 64'(stall_cycles), 64'd1);

        // Load-use on rm only counts when rm is used.
        idle_inputs(); ex_memread = 1'b1; ex_rd = 5'd7; id_rn = 5'd1; id_rm = 5'd7;
        step("rm_unused");
        chk("rm_unused_vec", 64'(last_obs), 64'd0);
        id_uses_rm = 1'b1;
        step("rm_used");
        chk("rm_used_vec", 64'(last_obs), 64'(7'b1110000));

        // Register 31 never hazards.
        idle_inputs(); ex_memread = 1'b1; ex_rd = 5'd31; id_rn = 5'd31; id_rm = 5'd31; id_uses_rm = 1'b1;
        step("r31");
        chk("r31_vec", 64'(last_obs), 64'd0);

        // Branch beats load-use.
        idle_inputs(); ex_memread = 1'b1; ex_rd = 5'd3; id_rn = 5'd3; ex_branch_taken = 1'b1;
        step("br_lu");
        chk("br_lu_vec", 64'(last_obs), 64'(7'b0001100));

        // Stray ack without request.
        idle_inputs(); mem_ack = 1'b1;
        step("stray_ack");
        chk("stray_ack_vec", 64'(last_obs), 64'd0);

        // Memory wait with a branch sitting in EX throughout.
        do_reset();
        mem_req = 1'b1; ex_branch_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_ack = (i == 4);
            step("mw_hold");
            chk("mw_hold_vec", 64'(last_obs), 64'(7'b1100010));
        end
        mem_req = 1'b0; mem_ack = 1'b0;
        step("mw_flush");
        chk("mw_flush_vec", 64'(last_obs), 64'(7'b0001100));
        chk("mw_sc", 64'(stall_cycles), 64'd5);

        // Timeout into FAULT, then recovery via Reset.
        do_reset();
        mem_req = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 8; i++) step("to_wait");
        chk("to_not_yet", 64'(mem_fault), 64'd0);
        step("to_last");
        chk("to_fault", 64'(mem_fault), 64'd1);
        mem_req = 1'b0; mem_ack = 1'b1;
        step("fault_hold");
        chk("fault_hold_vec", 64'(last_obs), 64'(7'b1100011));
        Reset = 1'b1;
        step("fault_rst");
        chk("fault_rst_vec", 64'(last_obs), 64'(7'b0000001));
        Reset = 1'b0;
        idle_inputs();
        chk("fault_cleared", 64'(mem_fault), 64'd0);
        chk("fault_sc_clr", 64'(stall_cycles), 64'd0);
        step("after_fault");
        chk("after_fault_vec", 64'(last_obs), 64'd0);

        // Randomized traffic; alternate phases of responsive and sluggish memory.
        for (int i = 0; i < 1500; i++) begin
            int ack_pct;
            ack_pct         = ((i / 250) % 2 == 0) ? 60 : 10;
            Reset           = ($urandom_range(0, 59) == 0);
            id_rn           = pick_reg();
            id_rm           = pick_reg();
            id_uses_rm      = $urandom_range(0, 1) == 1;
            ex_rd           = pick_reg();
            ex_memread      = $urandom_range(0, 1) == 1;
            ex_branch_taken = $urandom_range(0, 99) < 20;
            mem_req         = $urandom_range(0, 99) < 30;
            mem_ack         = $urandom_range(0, 99) < ack_pct;
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
